// File: rtl/spi_transfer_controller.sv
// SPI transfer sequencer: frames one word with csN/sclk and strobes an external
// shift register to load, shift and read back the data.
module spi_transfer_controller #(
    parameter int unsigned MAX_WORD_SIZE = 16,
    parameter int unsigned DIV_WIDTH     = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [$clog2(MAX_WORD_SIZE)-1:0] wordSize,
    input  logic [DIV_WIDTH-1:0]             clkDiv,
    input  logic                             cpol,
    input  logic                             miso,
    output logic                             sclk,
    output logic                             csN,
    output logic                             srEnable,
    output logic                             srWrite,
    output logic                             srShift,
    output logic                             srRead,
    output logic                             srShiftIn,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned WS_W   = $clog2(MAX_WORD_SIZE);
    localparam int unsigned EDGE_W = WS_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LEAD   = 3'd2,
        ACTIVE = 3'd3,
        TRAIL  = 3'd4,
        READ   = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t              state_q;
    logic [WS_W-1:0]     ws_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [EDGE_W-1:0]   edge_q;
    logic                sclk_q;
    logic                csn_q;
    logic                sren_q;
    logic                srwr_q;
    logic                srsh_q;
    logic                srrd_q;
    logic                srsi_q;
    logic                busy_q;
    logic                done_q;

    logic                half_done_c;
    logic                last_edge_c;

    // Half-period expiry and "next toggle is the final trailing edge" flags.
    // edge_q holds the 0-based index of the most recent visible edge.
    assign half_done_c = (cnt_q == div_q);
    assign last_edge_c = (edge_q == {ws_q, 1'b0});

    // Transfer sequencer with all outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ws_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            sren_q  <= 1'b0;
            srwr_q  <= 1'b0;
            srsh_q  <= 1'b0;
            srrd_q  <= 1'b0;
            srsi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            srwr_q <= 1'b0;
            srsh_q <= 1'b0;
            srrd_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    if (start) begin
                        ws_q    <= wordSize;
                        div_q   <= clkDiv;
                        csn_q   <= 1'b0;
                        sren_q  <= 1'b1;
                        srwr_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= LEAD;
                end
                LEAD: begin
                    if (half_done_c) begin
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        sclk_q  <= ~sclk_q;
                        srsi_q  <= miso;
                        state_q <= ACTIVE;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                ACTIVE: begin
                    if (half_done_c) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EDGE_W'(1);
                        if (edge_q[0]) begin
                            srsi_q <= miso;
                        end else begin
                            srsh_q <= 1'b1;
                        end
                        if (last_edge_c) begin
                            state_q <= TRAIL;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                TRAIL: begin
                    if (half_done_c) begin
                        cnt_q   <= '0;
                        csn_q   <= 1'b1;
                        srrd_q  <= 1'b1;
                        state_q <= READ;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                READ: begin
                    sren_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    sclk_q  <= cpol;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sclk      = sclk_q;
    assign csN       = csn_q;
    assign srEnable  = sren_q;
    assign srWrite   = srwr_q;
    assign srShift   = srsh_q;
    assign srRead    = srrd_q;
    assign srShiftIn = srsi_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Bench for spi_transfer_controller: cycle-by-cycle reference model plus
// directed timing scenarios and a randomized soak.
module tb_spi_transfer_controller;

    localparam int unsigned MW  = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned WSW = $clog2(MW);

    logic           clock    = 1'b0;
    logic           reset    = 1'b1;
    logic           start    = 1'b0;
    logic [WSW-1:0] wordSize = '0;
    logic [DW-1:0]  clkDiv   = '0;
    logic           cpol     = 1'b0;
    logic           miso     = 1'b0;
    logic sclk, csN, srEnable, srWrite, srShift, srRead, srShiftIn, busy, done;

    spi_transfer_controller #(.MAX_WORD_SIZE(MW), .DIV_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .wordSize(wordSize),
        .clkDiv(clkDiv), .cpol(cpol), .miso(miso), .sclk(sclk), .csN(csN),
        .srEnable(srEnable), .srWrite(srWrite), .srShift(srShift),
        .srRead(srRead), .srShiftIn(srShiftIn), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: one accepted transfer described by its start cycle and
    // latched settings; outputs are derived from the cycle offset.
    bit   m_act      = 1'b0;
    int   m_t0       = 0;
    int   m_n        = 1;
    int   m_d        = 0;
    logic m_pol      = 1'b0;
    logic m_sclk_idl = 1'b0;
    logic m_srsi     = 1'b0;

    // Per-transfer observations and the external shift register / slave.
    int xf_edges, xf_shifts, xf_dones, first_edge_cyc, last_edge_cyc, read_cyc, done_cyc;
    logic        last_sclk = 1'b0;
    logic [15:0] sr_word, load_word, mosi_word, slave_word;
    bit          slave_mode = 1'b0;
    int          dir_n = 8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, got, exp);
        end
    endtask

    // READ cycle offset from the start cycle.
    function automatic int xfer_read_off();
        return 2 + 2 * m_n * (m_d + 1) + m_d + 1;
    endfunction

    task automatic model_step();
        int off;
        int k;
        if (reset) begin
            m_act      = 1'b0;
            m_sclk_idl = 1'b0;
            m_srsi     = 1'b0;
        end else begin
            if (start && (!m_act || (cyc - 1 - m_t0) > xfer_read_off() + 1)) begin
                m_act = 1'b1;
                m_t0  = cyc - 1;
                m_n   = int'(wordSize) + 1;
                m_d   = int'(clkDiv);
                m_pol = cpol;
            end else if (m_act && (cyc - m_t0) > xfer_read_off() + 1) begin
                m_act = 1'b0;
            end
            m_sclk_idl = cpol;
            off = cyc - m_t0;
            if (m_act && off >= 2 && ((off - 2) % (m_d + 1)) == 0) begin
                k = (off - 2) / (m_d + 1);
                if ((k % 2) == 1 && k <= 2 * m_n) m_srsi = miso;
            end
        end
    endtask

    // {sclk, csN, srEnable, srWrite, srShift, srRead, srShiftIn, busy, done}
    function automatic logic [8:0] model_out();
        int off, r, k;
        logic s_sclk, s_csn, en, wr, sh, rd, bz, dn;
        s_sclk = m_sclk_idl; s_csn = 1'b1; en = 1'b0; wr = 1'b0;
        sh = 1'b0; rd = 1'b0; bz = 1'b0; dn = 1'b0;
        if (m_act) begin
            off = cyc - m_t0;
            r   = xfer_read_off();
            if (off >= 1 && off <= r + 1) begin
                bz = 1'b1;
                s_sclk = m_pol;
                if (off == 1) begin
                    s_csn = 1'b0; en = 1'b1; wr = 1'b1;
                end else if (off < r) begin
                    s_csn = 1'b0; en = 1'b1;
                    k = (off - 2) / (m_d + 1);
                    s_sclk = m_pol ^ ((k % 2) == 1);
                    if (((off - 2) % (m_d + 1)) == 0 && k >= 1 && (k % 2) == 0) sh = 1'b1;
                end else if (off == r) begin
                    en = 1'b1; rd = 1'b1;
                end else begin
                    dn = 1'b1;
                end
            end
        end
        return {s_sclk, s_csn, en, wr, sh, rd, m_srsi, bz, dn};
    endfunction

    task automatic observe();
        if (!reset && busy && sclk !== last_sclk) begin
            xf_edges++;
            if (xf_edges == 1) first_edge_cyc = cyc;
            last_edge_cyc = cyc;
        end
        last_sclk = sclk;
        if (srShift) begin
            xf_shifts++;
            mosi_word = {mosi_word[14:0], sr_word[m_n-1]};
            sr_word   = {sr_word[14:0], srShiftIn};
        end
        if (srWrite) sr_word = load_word;
        if (srRead)  read_cyc = cyc;
        if (done) begin
            xf_dones++;
            done_cyc = cyc;
        end
    endtask

    // One clock: sample at the falling edge, advance model, compare, observe.
    task automatic tick();
        logic [8:0] e;
        @(negedge clock);
        cyc++;
        model_step();
        e = model_out();
        check("cycle_outputs",
              {23'd0, sclk, csN, srEnable, srWrite, srShift, srRead, srShiftIn, busy, done},
              {23'd0, e});
        observe();
        if (slave_mode) begin
            int idx;
            idx  = dir_n - 1 - xf_shifts;
            miso = (idx >= 0) ? slave_word[idx] : 1'b0;
        end
    endtask

    task automatic clear_obs();
        xf_edges = 0; xf_shifts = 0; xf_dones = 0;
        first_edge_cyc = -1; last_edge_cyc = -1; read_cyc = -1; done_cyc = -1;
        sr_word = '0; mosi_word = '0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (!busy) break;
        end
        check("reach_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t;
        clear_obs();
        load_word  = 16'h0000;
        slave_word = 16'h0000;

        tick();
        check("reset_vector",
              {23'd0, sclk, csN, srEnable, srWrite, srShift, srRead, srShiftIn, busy, done},
              32'h080);
        tick();
        reset = 1'b0;
        tick();

        // 8-bit, clock/2, mode 0, slave returns 0xA5, shift register holds 0x3C
        clear_obs();
        cpol = 1'b0; clkDiv = 8'd0; wordSize = 4'd7; dir_n = 8;
        load_word = 16'h003C; slave_word = 16'h00A5; slave_mode = 1'b1;
        miso = slave_word[7];
        t = cyc; start = 1'b1;
        tick(); start = 1'b0;
        check("load_state", {29'd0, busy, srWrite, csN}, 32'h6);
        wait_idle(100);
        check("w8_first_edge", first_edge_cyc, t + 3);
        check("w8_last_edge",  last_edge_cyc,  t + 18);
        check("w8_edges",      xf_edges,       16);
        check("w8_shifts",     xf_shifts,      8);
        check("w8_read",       read_cyc,       t + 19);
        check("w8_done",       done_cyc,       t + 20);
        check("w8_mosi",       {24'd0, mosi_word[7:0]}, 32'h3C);
        check("w8_dataout",    {16'd0, 8'h00, sr_word[7:0]}, 32'h00A5);
        slave_mode = 1'b0;

        // 16-bit, half period 4 cycles, sclk idles high
        cpol = 1'b1; clkDiv = 8'd3; wordSize = 4'd15;
        tick();
        clear_obs();
        load_word = 16'hBEEF;
        t = cyc; start = 1'b1;
        tick(); start = 1'b0;
        check("w16_idle_high", {31'd0, sclk}, 32'd1);
        wait_idle(300);
        check("w16_first_edge", first_edge_cyc, t + 6);
        check("w16_last_edge",  last_edge_cyc,  t + 130);
        check("w16_edges",      xf_edges,       32);
        check("w16_shifts",     xf_shifts,      16);
        check("w16_done",       done_cyc,       t + 135);

        // start during a transfer is dropped; start right after done is taken
        cpol = 1'b0; clkDiv = 8'd1; wordSize = 4'd3;
        tick();
        clear_obs();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b1;
        tick(); start = 1'b0;
        wait_idle(100);
        check("busy_start_ignored", xf_dones, 1);
        clear_obs();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) break;
        end
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        check("restart_after_done", {31'd0, busy}, 32'd1);
        wait_idle(100);
        check("restart_done_count", xf_dones, 2);

        // reset at edge 7 aborts cleanly, next transfer is normal
        cpol = 1'b0; clkDiv = 8'd0; wordSize = 4'd7;
        tick();
        clear_obs();
        start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (xf_edges >= 7) break;
        end
        reset = 1'b1;
        #1;
        check("abort_now", {29'd0, csN, sclk, busy}, 32'h4);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("abort_no_done", xf_dones, 0);
        clear_obs();
        t = cyc; start = 1'b1;
        tick(); start = 1'b0;
        wait_idle(100);
        check("post_abort_done", done_cyc, t + 20);
        check("post_abort_edges", xf_edges, 16);

        // randomized soak
        for (int i = 0; i < 6000; i++) begin
            tick();
            start    = ($urandom_range(0, 9) == 0);
            wordSize = WSW'($urandom);
            clkDiv   = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) cpol = ~cpol;
            miso     = 1'($urandom);
            if (reset) reset = 1'b0;
            else       reset = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
